// File: rtl/status_flag_unit.sv
// -----------------------------------------------------------------------------
// status_flag_unit
//
// Architectural NZCV flag holder that feeds the condition-check stage. Flags
// are packed {Z, C, N, V} (bit 3 = Z, bit 2 = C, bit 1 = N, bit 0 = V).
// Next flags come from the execute-stage ALU result. Stall (freeze) and squash
// (flush) are honoured. One shadow copy supports exception save/restore. An
// optional combinational bypass exposes the flags the next instruction must see.
//
// Ports:
//   clk        : clock, all state updates on the rising edge
//   rst        : asynchronous, active-low reset
//   freeze     : pipeline stall, all state holds
//   flush      : squash the current execute-stage instruction (no flag write)
//   upd_en     : execute-stage instruction valid with S bit set
//   upd_kind   : 00 arithmetic, 01 logical, 10 restore-from-shadow, 11 no-op
//   alu_res    : ALU result, used for N/Z derivation
//   alu_c      : adder carry-out
//   alu_v      : adder overflow
//   shf_c      : shifter carry-out, used by logical ops
//   save_req   : copy the current flags into the shadow register
//   status_out : registered flags {Z, C, N, V}
//   status_fwd : flags as the next instruction must see them
//   shadow_out : shadow register contents {Z, C, N, V}
//   upd_count  : committed flag writes, modulo 2^CNT_W
// -----------------------------------------------------------------------------
module status_flag_unit #(
    parameter int DATA_W = 32,
    parameter bit BYPASS = 1'b1,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              upd_en,
    input  logic [1:0]        upd_kind,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              alu_c,
    input  logic              alu_v,
    input  logic              shf_c,
    input  logic              save_req,
    output logic [3:0]        status_out,
    output logic [3:0]        status_fwd,
    output logic [3:0]        shadow_out,
    output logic [CNT_W-1:0]  upd_count
);

    localparam logic [1:0] KIND_ARITH   = 2'b00;
    localparam logic [1:0] KIND_LOGIC   = 2'b01;
    localparam logic [1:0] KIND_RESTORE = 2'b10;
    localparam logic [1:0] KIND_NOP     = 2'b11;

    logic [3:0]       status_r;
    logic [3:0]       shadow_r;
    logic [CNT_W-1:0] count_r;
    logic [3:0]       nf_s;
    logic             eff_s;
    logic             zero_s;
    logic             neg_s;

    // Zero detect on the full ALU result width.
    function automatic logic is_zero(input logic [DATA_W-1:0] value);
        return (value == {DATA_W{1'b0}});
    endfunction

    assign zero_s = is_zero(alu_res);
    assign neg_s  = alu_res[DATA_W-1];

    // A write only commits for a live, unstalled, unsquashed, non-nop update.
    assign eff_s = upd_en & ~flush & ~freeze & (upd_kind != KIND_NOP);

    // Next-flag selection by update kind.
    always_comb begin
        nf_s = status_r;
        case (upd_kind)
            KIND_ARITH:   nf_s = {zero_s, alu_c, neg_s, alu_v};
            // Logical ops take carry from the shifter and leave V untouched.
            KIND_LOGIC:   nf_s = {zero_s, shf_c, neg_s, status_r[0]};
            KIND_RESTORE: nf_s = shadow_r;
            default:      nf_s = status_r;
        endcase
    end

    // Bypass path; forced to zero while reset is held so nothing leaks from nf.
    always_comb begin
        status_fwd = 4'b0000;
        if (!rst) begin
            status_fwd = 4'b0000;
        end else if (BYPASS && eff_s) begin
            status_fwd = nf_s;
        end else begin
            status_fwd = status_r;
        end
    end

    // Flag, shadow and counter registers. Shadow captures the pre-update flags,
    // so save + restore in one cycle swaps the two registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_r <= 4'b0000;
            shadow_r <= 4'b0000;
            count_r  <= {CNT_W{1'b0}};
        end else if (!freeze) begin
            if (eff_s) begin
                status_r <= nf_s;
                count_r  <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (save_req) begin
                shadow_r <= status_r;
            end
        end
    end

    assign status_out = status_r;
    assign shadow_out = shadow_r;
    assign upd_count  = count_r;

endmodule

// File: tb/tb_status_flag_unit.sv
// -----------------------------------------------------------------------------
// tb_status_flag_unit
//
// Directed-vector bench. The stimulus process drives one vector per cycle just
// after the rising edge and pushes the hand-computed response expected at the
// following falling edge. A separate monitor pops and compares on each falling
// edge.
// -----------------------------------------------------------------------------
module tb_status_flag_unit;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        flush;
    logic        upd_en;
    logic [1:0]  upd_kind;
    logic [31:0] alu_res;
    logic        alu_c;
    logic        alu_v;
    logic        shf_c;
    logic        save_req;
    logic [3:0]  status_out;
    logic [3:0]  status_fwd;
    logic [3:0]  shadow_out;
    logic [7:0]  upd_count;

    typedef struct {
        string      name;
        logic [3:0] st;
        logic [3:0] fwd;
        logic [3:0] sh;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt;
    int   total_cnt;

    status_flag_unit #(
        .DATA_W (32),
        .BYPASS (1'b1),
        .CNT_W  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .freeze     (freeze),
        .flush      (flush),
        .upd_en     (upd_en),
        .upd_kind   (upd_kind),
        .alu_res    (alu_res),
        .alu_c      (alu_c),
        .alu_v      (alu_v),
        .shf_c      (shf_c),
        .save_req   (save_req),
        .status_out (status_out),
        .status_fwd (status_fwd),
        .shadow_out (shadow_out),
        .upd_count  (upd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic en, input logic [1:0] kind,
                         input logic [31:0] res, input logic c, input logic v,
                         input logic sc, input logic save,
                         input logic frz, input logic fl);
        upd_en   = en;
        upd_kind = kind;
        alu_res  = res;
        alu_c    = c;
        alu_v    = v;
        shf_c    = sc;
        save_req = save;
        freeze   = frz;
        flush    = fl;
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push_exp(input string name, input logic [3:0] st,
                            input logic [3:0] fwd, input logic [3:0] sh,
                            input logic [7:0] cnt);
        exp_t e;
        e.name = name;
        e.st   = st;
        e.fwd  = fwd;
        e.sh   = sh;
        e.cnt  = cnt;
        exp_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check4(input string name, input string field,
                          input logic [3:0] act, input logic [3:0] req);
        total_cnt++;
        if (act === req) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s.%s: got %b, expected %b", name, field, act, req);
        end
    endtask

    // Monitor: one expectation per falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check4(e.name, "status_out", status_out, e.st);
            check4(e.name, "status_fwd", status_fwd, e.fwd);
            check4(e.name, "shadow_out", shadow_out, e.sh);
            total_cnt++;
            if (upd_count === e.cnt) begin
                pass_cnt++;
            end else begin
                $display("FAIL %s.upd_count: got %0d, expected %0d", e.name, upd_count, e.cnt);
            end
        end
    end

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst       = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;

        // In reset with a live update: fwd must stay zero.
        drive(1'b1, 2'b00, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_exp("in_reset", 4'b0000, 4'b0000, 4'b0000, 8'd0);
        next_cycle();

        // Reset release, idle.
        rst = 1'b1;
        idle();
        push_exp("reset_release", 4'b0000, 4'b0000, 4'b0000, 8'd0);
        next_cycle();

        // Arithmetic zero result with carry -> 1100.
        drive(1'b1, 2'b00, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_exp("arith_fwd", 4'b0000, 4'b1100, 4'b0000, 8'd0);
        next_cycle();
        idle();
        push_exp("arith_commit", 4'b1100, 4'b1100, 4'b0000, 8'd1);
        next_cycle();

        // Arithmetic to set Z=1 C=1 N=0 V=1.
        drive(1'b1, 2'b00, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push_exp("arith_zcv", 4'b1100, 4'b1101, 4'b0000, 8'd1);
        next_cycle();

        // Logical: N from bit 31, C from shifter, V held (alu_c/alu_v ignored).
        drive(1'b1, 2'b01, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_exp("logic_fwd", 4'b1101, 4'b0011, 4'b0000, 8'd2);
        next_cycle();
        idle();
        push_exp("logic_commit", 4'b0011, 4'b0011, 4'b0000, 8'd3);
        next_cycle();

        // Freeze for 3 cycles with update and save pending: nothing moves.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b00, 32'h0000_0005, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
            push_exp("freeze", 4'b0011, 4'b0011, 4'b0000, 8'd3);
            next_cycle();
        end
        // Flush squashes the update.
        drive(1'b1, 2'b00, 32'h0000_0005, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        push_exp("flush", 4'b0011, 4'b0011, 4'b0000, 8'd3);
        next_cycle();
        // Flush plus freeze with save: behaves as freeze.
        drive(1'b1, 2'b00, 32'h0000_0005, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        push_exp("flush_freeze", 4'b0011, 4'b0011, 4'b0000, 8'd3);
        next_cycle();
        idle();
        push_exp("post_flush", 4'b0011, 4'b0011, 4'b0000, 8'd3);
        next_cycle();

        // Set flags to 1100 for the save/restore sequence.
        drive(1'b1, 2'b00, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_exp("setup_1100", 4'b0011, 4'b1100, 4'b0000, 8'd3);
        next_cycle();
        // Save with same-cycle arithmetic producing 0101: shadow gets 1100.
        drive(1'b1, 2'b00, 32'h0000_0001, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        push_exp("save_arith", 4'b1100, 4'b0101, 4'b0000, 8'd4);
        next_cycle();
        // Restore with save: swap.
        drive(1'b1, 2'b10, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        push_exp("swap_fwd", 4'b0101, 4'b1100, 4'b1100, 8'd5);
        next_cycle();
        idle();
        push_exp("swap_done", 4'b1100, 4'b1100, 4'b0101, 8'd6);
        next_cycle();

        // Kind 11 and upd_en=0 never commit.
        drive(1'b1, 2'b11, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        push_exp("kind_nop", 4'b1100, 4'b1100, 4'b0101, 8'd6);
        next_cycle();
        drive(1'b0, 2'b00, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push_exp("no_enable", 4'b1100, 4'b1100, 4'b0101, 8'd6);
        next_cycle();

        // 250 commits take the counter from 6 through 255 to 0.
        for (int i = 0; i < 250; i++) begin
            drive(1'b1, 2'b00, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            push_exp("wrap_loop", 4'b1100, 4'b1100, 4'b0101, 8'(6 + i));
            next_cycle();
        end
        idle();
        push_exp("wrap_zero", 4'b1100, 4'b1100, 4'b0101, 8'd0);
        next_cycle();
        drive(1'b1, 2'b00, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_exp("pre_reset", 4'b1100, 4'b1100, 4'b0101, 8'd0);
        next_cycle();

        // Reset mid-stream, asserted between edges: checked before the next edge.
        rst = 1'b0;
        drive(1'b1, 2'b00, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        push_exp("async_reset", 4'b0000, 4'b0000, 4'b0000, 8'd0);
        next_cycle();

        // First edge after release commits normally.
        rst = 1'b1;
        drive(1'b1, 2'b00, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push_exp("reset_exit_fwd", 4'b0000, 4'b0011, 4'b0000, 8'd0);
        next_cycle();
        idle();
        push_exp("reset_exit_commit", 4'b0011, 4'b0011, 4'b0000, 8'd1);
        next_cycle();

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        total_cnt++;
        if (exp_q.size() == 0) begin
            pass_cnt++;
        end else begin
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/status_flag_unit.md
Name: status_flag_unit

Overview:
- Holds the processor's architectural NZCV flags.
- Sits directly upstream of the condition-check stage and drives its 4-bit status input, packed {Z, C, N, V}.
- Computes the next flags from execute-stage ALU results, honours stall and flush, and keeps one shadow copy for exception save/restore.
- Optional same-cycle bypass lets the condition check see flags written by the immediately preceding instruction.

Parameters:
DATA_W, 32, ALU result width used for N/Z derivation
BYPASS, 1, 1 = status_fwd reflects this cycle's update; 0 = status_fwd equals status_out
CNT_W, 8, width of the flag-write event counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset
freeze  in  1  pipeline stall; all state holds
flush  in  1  squash the current execute-stage instruction; no flag update this cycle
upd_en  in  1  execute-stage instruction is valid and has its S bit set
upd_kind  in  2  00 arithmetic, 01 logical, 10 restore-from-shadow, 11 no-op
alu_res  in  DATA_W  ALU result
alu_c  in  1  adder carry-out
alu_v  in  1  adder overflow
shf_c  in  1  shifter carry-out, used by logical ops
save_req  in  1  copy the current flags into the shadow register
status_out  out  4  registered flags {Z, C, N, V}
status_fwd  out  4  flags as the next instruction must see them (bypass path)
shadow_out  out  4  shadow register contents {Z, C, N, V}
upd_count  out  CNT_W  number of committed flag writes, modulo 2^CNT_W

Behaviour:
- Reset (rst low, asynchronous): status_out = 4'b0000, shadow_out = 4'b0000, upd_count = 0. status_fwd = 0000 while reset is asserted.
- Effective update: eff = upd_en & ~flush & ~freeze & (upd_kind != 11).
- Next flags (nf), evaluated combinationally:
  - kind 00: Z = (alu_res == 0), C = alu_c, N = alu_res[DATA_W-1], V = alu_v.
  - kind 01: Z and N as for kind 00; C = shf_c; V = current V (held).
  - kind 10: nf = shadow_out.
  - otherwise: nf = status_out.
- Commit: on a rising edge with eff = 1, status_out <= nf and upd_count <= upd_count + 1, wrapping from 2^CNT_W-1 to 0.
- Latency: one cycle from the update inputs to status_out.
- status_fwd: with BYPASS = 1 it equals nf when eff = 1, else status_out; this is purely combinational with zero latency. With BYPASS = 0 it always equals status_out.
- Shadow save: on a rising edge with save_req = 1 and freeze = 0, shadow_out <= status_out. This is the pre-update value, even if eff = 1 in the same cycle.
- Save and restore in the same cycle (save_req = 1, eff = 1, kind 10): status_out and shadow_out swap.
- flush has no effect on save_req, which comes from the exception controller, not the pipeline.
- freeze = 1: status_out, shadow_out and upd_count all hold. status_fwd = status_out regardless of the update inputs.
- flush and freeze together: treated as freeze, so nothing changes.
- Reset asserted mid-operation: every register clears immediately. The first edge after rst goes high may commit an update normally.
- No other state; there is no FSM beyond the flag, shadow and counter registers.

Test Plan:
1. Reset then release, all inputs idle -> status_out = 0000, shadow_out = 0000, upd_count = 0.
2. Arithmetic op: upd_en = 1, kind 00, alu_res = 0x00000000, alu_c = 1, alu_v = 0 -> status_fwd = 1100 in the same cycle; status_out = 1100 after the edge; upd_count = 1.
3. Logical op on flags Z=1, C=1, N=0, V=1: kind 01, alu_res = 0x80000000, shf_c = 0 -> status_out = 0011 (Z = 0, C = 0, N = 1, V held at 1).
4. Update held by freeze = 1 for 3 cycles, then flush = 1 for 1 cycle -> status_out and upd_count unchanged throughout; status_fwd = status_out.
5. Flags 1010; save_req = 1 together with an arithmetic update producing 0101 -> shadow_out = 1010 and status_out = 0101. Next cycle, kind 10 with save_req = 1 -> status_out = 1010, shadow_out = 0101.
6. CNT_W = 8: issue 256 committed updates -> upd_count wraps to 0. Assert rst low mid-stream -> every output clears immediately, without waiting for a clock edge.
